// File: rtl/cfu_mac_sequencer.sv
// CFU sequencer: runs an int8 dot-product job over two SRAM banks through an
// external 4-lane SIMD MAC and returns the accumulator on the CPU rsp channel.
module cfu_mac_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int LEN_W   = 12,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_payload_function_id,
  input  logic [31:0]       cmd_payload_inputs_0,
  input  logic [31:0]       cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_payload_outputs_0,
  output logic [ADDR_W-1:0] mem_a_addr,
  output logic [ADDR_W-1:0] mem_b_addr,
  output logic              mem_a_rd,
  output logic              mem_b_rd,
  input  logic [31:0]       mem_a_data,
  input  logic [31:0]       mem_b_data,
  output logic              mac_clear,
  output logic              mac_in_valid,
  output logic [31:0]       mac_in_a,
  output logic [31:0]       mac_in_b,
  output logic [8:0]        mac_offset,
  input  logic [31:0]       mac_acc
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  localparam logic [6:0] OP_CFG_BASE   = 7'd0;
  localparam logic [6:0] OP_SET_OFFSET = 7'd1;
  localparam logic [6:0] OP_START      = 7'd2;
  localparam logic [6:0] OP_STATUS     = 7'd3;
  localparam logic [7:0] DRAIN_LAST    = 8'(MAC_LAT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_a_q, base_a_d;
  logic [ADDR_W-1:0]   base_b_q, base_b_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [7:0]          drain_q, drain_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                mac_in_valid_q, mac_in_valid_d;
  logic                mac_clear_q, mac_clear_d;
  logic [8:0]          mac_offset_q, mac_offset_d;
  logic                busy_q, busy_d;

  logic                cmd_fire;
  logic                mem_rd;
  logic [6:0]          opcode;
  logic [ADDR_W-1:0]   idx_addr;
  logic                unused_cmd_bits;

  assign opcode          = cmd_payload_function_id[9:3];
  assign cmd_ready       = (state_q == IDLE) && !rsp_valid_q;
  assign cmd_fire        = cmd_valid && cmd_ready;
  assign mem_rd          = (state_q == ISSUE);
  assign idx_addr        = ADDR_W'(idx_q);
  assign unused_cmd_bits = ^{cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};

  assign mem_a_rd   = mem_rd;
  assign mem_b_rd   = mem_rd;
  assign mem_a_addr = mem_rd ? base_a_q + idx_addr : '0;
  assign mem_b_addr = mem_rd ? base_b_q + idx_addr : '0;

  // Operands flow straight from SRAM; the valid is gated so a reset drops in-flight reads at once.
  assign mac_in_valid          = mac_in_valid_q && reset;
  assign mac_in_a              = mem_a_data;
  assign mac_in_b              = mem_b_data;
  assign mac_clear             = mac_clear_q;
  assign mac_offset            = mac_offset_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

  always_comb begin
    state_d        = state_q;
    base_a_d       = base_a_q;
    base_b_d       = base_b_q;
    len_d          = len_q;
    idx_d          = idx_q;
    drain_d        = drain_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    mac_offset_d   = mac_offset_q;
    busy_d         = busy_q;
    mac_clear_d    = 1'b0;
    mac_in_valid_d = mem_rd;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
          case (opcode)
            OP_CFG_BASE: begin
              base_a_d   = cmd_payload_inputs_0[ADDR_W-1:0];
              base_b_d   = cmd_payload_inputs_1[ADDR_W-1:0];
              rsp_data_d = 32'd0;
            end
            OP_SET_OFFSET: begin
              mac_offset_d = cmd_payload_inputs_0[8:0];
              rsp_data_d   = 32'd0;
            end
            OP_START: begin
              len_d       = cmd_payload_inputs_1[LEN_W-1:0];
              idx_d       = '0;
              drain_d     = '0;
              busy_d      = 1'b1;
              rsp_valid_d = 1'b0;
              mac_clear_d = !cmd_payload_function_id[0];
              state_d     = (cmd_payload_inputs_1[LEN_W-1:0] == '0) ? DRAIN : ISSUE;
            end
            OP_STATUS: rsp_data_d = {31'd0, busy_q};
            default:   rsp_data_d = 32'hFFFF_FFFF;
          endcase
        end
      end
      ISSUE: begin
        idx_d = idx_q + LEN_W'(1);
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Last operand reaches mac_acc MAC_LAT cycles after its valid, one cycle after its read.
        if (drain_q == DRAIN_LAST) begin
          rsp_data_d  = mac_acc;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      base_a_q       <= '0;
      base_b_q       <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      drain_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 32'd0;
      mac_in_valid_q <= 1'b0;
      mac_clear_q    <= 1'b0;
      mac_offset_q   <= 9'd128;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_a_q       <= base_a_d;
      base_b_q       <= base_b_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      drain_q        <= drain_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      mac_in_valid_q <= mac_in_valid_d;
      mac_clear_q    <= mac_clear_d;
      mac_offset_q   <= mac_offset_d;
      busy_q         <= busy_d;
    end
  end

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Bench for cfu_mac_sequencer: SRAM and MAC datapath models plus a response scoreboard.
module tb_cfu_mac_sequencer;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [9:0]    cmd_payload_function_id = '0;
  logic [31:0]   cmd_payload_inputs_0 = '0;
  logic [31:0]   cmd_payload_inputs_1 = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_payload_outputs_0;
  logic [AW-1:0] mem_a_addr, mem_b_addr;
  logic          mem_a_rd, mem_b_rd;
  logic [31:0]   mem_a_data, mem_b_data;
  logic          mac_clear, mac_in_valid;
  logic [31:0]   mac_in_a, mac_in_b;
  logic [8:0]    mac_offset;
  logic [31:0]   mac_acc;

  cfu_mac_sequencer #(.ADDR_W(AW), .LEN_W(12), .MAC_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
    .mem_a_rd(mem_a_rd), .mem_b_rd(mem_b_rd),
    .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
    .mac_clear(mac_clear), .mac_in_valid(mac_in_valid),
    .mac_in_a(mac_in_a), .mac_in_b(mac_in_b),
    .mac_offset(mac_offset), .mac_acc(mac_acc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_acc = 0;
  int clear_cnt = 0;
  int rd_cnt = 0;
  int overlap_cnt = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem_a [0:4095];
  logic [31:0] mem_b [0:4095];
  logic [31:0] acc_m = 32'd0;

  function automatic logic [31:0] lane_sum(input logic [31:0] a, input logic [31:0] b,
                                           input logic [8:0] off);
    int s;
    logic signed [7:0] av, bv;
    logic signed [8:0] o;
    s = 0;
    o = off;
    for (int l = 0; l < 4; l++) begin
      av = a[l*8 +: 8];
      bv = b[l*8 +: 8];
      s += (int'(av) + int'(o)) * int'(bv);
    end
    return 32'(s);
  endfunction

  function automatic logic [31:0] exp_dot(input int ba, input int bb, input int len,
                                          input logic [8:0] off, input logic [31:0] init);
    logic [31:0] acc;
    acc = init;
    for (int i = 0; i < len; i++)
      acc = acc + lane_sum(mem_a[(ba + i) % 4096], mem_b[(bb + i) % 4096], off);
    return acc;
  endfunction

  // SRAM banks with one-cycle registered read, and the external MAC datapath.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_a_rd) mem_a_data <= mem_a[mem_a_addr];
    if (mem_b_rd) mem_b_data <= mem_b[mem_b_addr];
    if (mac_clear) acc_m <= 32'd0;
    else if (mac_in_valid) acc_m <= acc_m + lane_sum(mac_in_a, mac_in_b, mac_offset);
  end
  assign mac_acc = acc_m;

  always @(negedge clk) begin
    if (mac_clear) clear_cnt <= clear_cnt + 1;
    if (mem_a_rd || mem_b_rd) rd_cnt <= rd_cnt + 1;
    if (mac_clear && mac_in_valid) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic send_cmd(input logic [6:0] op, input logic keep, input logic [31:0] in0,
                          input logic [31:0] in1, input logic [31:0] exp_data, input int exp_lat);
    int n;
    exp_t e;
    n = 0;
    cmd_payload_function_id = {op, 2'b00, keep};
    cmd_payload_inputs_0 = in0;
    cmd_payload_inputs_1 = in1;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL cmd_accept op=%0d: cmd_ready=%b required 1 within 200 cycles", op, cmd_ready);
      miscompares++;
    end
    t_acc = cyc;
    e.data = exp_data;
    e.lat = exp_lat;
    sb.push_back(e);
    $display("cmd  op=%0d keep=%b in0=%h in1=%h accepted at cycle %0d", op, keep, in0, in1, t_acc);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name);
    int n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL %s rsp_timeout: rsp_valid=%b required 1", name, rsp_valid);
      miscompares++;
    end
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard_empty: got rsp %h with no expectation", name, rsp_payload_outputs_0);
      miscompares++;
    end else begin
      e = sb.pop_front();
      vectors++;
      if (cyc - t_acc !== e.lat) begin
        $display("FAIL %s latency: got %0d required %0d", name, cyc - t_acc, e.lat);
        miscompares++;
      end
      vectors++;
      if (rsp_payload_outputs_0 !== e.data) begin
        $display("FAIL %s data: got %h required %h", name, rsp_payload_outputs_0, e.data);
        miscompares++;
      end
      $display("rsp  %s data=%h latency=%0d (expected %h/%0d)", name, rsp_payload_outputs_0,
               cyc - t_acc, e.data, e.lat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL %s rsp_drop: rsp_valid=%b required 0 after handshake", name, rsp_valid);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_payload_outputs_0, mem_a_rd, mem_b_rd, mem_a_addr, mem_b_addr,
         mac_clear, mac_in_valid, mac_offset} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 12'd0, 12'd0,
         1'b0, 1'b0, 9'd128}) begin
      $display("FAIL reset_outputs: rdy=%b rv=%b rd=%h ard=%b brd=%b aa=%h ba=%h clr=%b iv=%b off=%h",
               cmd_ready, rsp_valid, rsp_payload_outputs_0, mem_a_rd, mem_b_rd, mem_a_addr,
               mem_b_addr, mac_clear, mac_in_valid, mac_offset);
      miscompares++;
    end
    $display("reset outputs checked");
    reset = 1'b1;
    @(negedge clk);
    send_cmd(7'd3, 1'b0, 32'd0, 32'd0, 32'd0, 1);
    get_rsp("status_after_reset");
  endtask

  task automatic test_basic_job();
    int c0;
    send_cmd(7'd1, 1'b0, 32'd128, 32'd0, 32'd0, 1);
    get_rsp("set_offset");
    vectors++;
    if (mac_offset !== 9'd128) begin
      $display("FAIL offset_value: got %h required %h", mac_offset, 9'd128);
      miscompares++;
    end
    send_cmd(7'd0, 1'b0, 32'd0, 32'h100, 32'd0, 1);
    get_rsp("cfg_base");
    c0 = clear_cnt;
    send_cmd(7'd2, 1'b0, 32'd0, 32'd4, 32'd4128, 7);
    get_rsp("start_len4");
    vectors++;
    if (clear_cnt - c0 !== 1) begin
      $display("FAIL clear_pulses_first: got %0d required 1", clear_cnt - c0);
      miscompares++;
    end
  endtask

  task automatic test_chain();
    int c0;
    c0 = clear_cnt;
    send_cmd(7'd2, 1'b1, 32'd0, 32'd4, 32'd8256, 7);
    get_rsp("start_keep");
    vectors++;
    if (clear_cnt - c0 !== 0) begin
      $display("FAIL clear_pulses_keep: got %0d required 0", clear_cnt - c0);
      miscompares++;
    end
    c0 = clear_cnt;
    send_cmd(7'd2, 1'b0, 32'd0, 32'd4, 32'd4128, 7);
    get_rsp("start_reclear");
    vectors++;
    if (clear_cnt - c0 !== 1) begin
      $display("FAIL clear_pulses_reclear: got %0d required 1", clear_cnt - c0);
      miscompares++;
    end
  endtask

  task automatic test_len_zero();
    int r0;
    r0 = rd_cnt;
    send_cmd(7'd2, 1'b0, 32'd0, 32'd0, 32'd0, 3);
    get_rsp("len0_clear");
    vectors++;
    if (rd_cnt - r0 !== 0) begin
      $display("FAIL len0_reads: got %0d read cycles required 0", rd_cnt - r0);
      miscompares++;
    end
    send_cmd(7'd2, 1'b0, 32'd0, 32'd4, 32'd4128, 7);
    get_rsp("len4_before_keep0");
    send_cmd(7'd2, 1'b1, 32'd0, 32'd0, 32'd4128, 3);
    get_rsp("len0_keep");
  endtask

  task automatic test_patterns();
    send_cmd(7'd1, 1'b0, 32'h1F0, 32'd0, 32'd0, 1);
    get_rsp("set_offset_neg");
    vectors++;
    if (mac_offset !== 9'h1F0) begin
      $display("FAIL offset_neg_value: got %h required %h", mac_offset, 9'h1F0);
      miscompares++;
    end
    send_cmd(7'd2, 1'b0, 32'd0, 32'd4, 32'hFFFF_FE20, 7);
    get_rsp("start_offset_neg");
    send_cmd(7'd1, 1'b0, 32'd128, 32'd0, 32'd0, 1);
    get_rsp("set_offset_restore");
    send_cmd(7'd0, 1'b0, 32'hFFE, 32'h0FE, 32'd0, 1);
    get_rsp("cfg_base_wrap");
    send_cmd(7'd2, 1'b0, 32'd0, 32'd4, exp_dot(12'hFFE, 12'h0FE, 4, 9'd128, 32'd0), 7);
    get_rsp("start_wrap");
    send_cmd(7'd9, 1'b0, 32'h55, 32'h66, 32'hFFFF_FFFF, 1);
    get_rsp("bad_opcode");
    vectors++;
    if (mac_offset !== 9'd128) begin
      $display("FAIL bad_opcode_state: offset %h required %h", mac_offset, 9'd128);
      miscompares++;
    end
  endtask

  task automatic test_hold();
    int n;
    logic [31:0] held;
    exp_t e;
    send_cmd(7'd0, 1'b0, 32'd0, 32'h100, 32'd0, 1);
    get_rsp("cfg_base_hold");
    send_cmd(7'd2, 1'b0, 32'd0, 32'd4, 32'd4128, 7);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || cyc - t_acc !== e.lat || rsp_payload_outputs_0 !== e.data) begin
      $display("FAIL hold_first_rsp: valid=%b lat=%0d data=%h required 1/%0d/%h", rsp_valid,
               cyc - t_acc, rsp_payload_outputs_0, e.lat, e.data);
      miscompares++;
    end
    held = e.data;
    cmd_payload_function_id = {7'd3, 3'b000};
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_payload_outputs_0 !== held || cmd_ready !== 1'b0) begin
        $display("FAIL hold_cycle%0d: valid=%b data=%h cmd_ready=%b required 1/%h/0", i, rsp_valid,
                 rsp_payload_outputs_0, cmd_ready, held);
        miscompares++;
      end
      $display("hold cycle %0d rsp_valid=%b data=%h cmd_ready=%b", i, rsp_valid,
               rsp_payload_outputs_0, cmd_ready);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL hold_release: rsp_valid=%b required 0", rsp_valid);
      miscompares++;
    end
    send_cmd(7'd3, 1'b0, 32'd0, 32'd0, 32'd0, 1);
    get_rsp("status_after_hold");
  endtask

  task automatic test_reset_mid_job();
    send_cmd(7'd1, 1'b0, 32'd5, 32'd0, 32'd0, 1);
    get_rsp("set_offset5");
    send_cmd(7'd2, 1'b0, 32'd0, 32'd8, 32'd0, 11);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (mac_in_valid !== 1'b0) begin
      $display("FAIL reset_cycle_in_valid: got %b required 0", mac_in_valid);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, mac_in_valid, mac_offset, mem_a_rd, cmd_ready, rsp_payload_outputs_0} !==
        {1'b0, 1'b0, 9'd128, 1'b0, 1'b1, 32'd0}) begin
      $display("FAIL mid_reset_state: rv=%b iv=%b off=%h rd=%b rdy=%b data=%h", rsp_valid,
               mac_in_valid, mac_offset, mem_a_rd, cmd_ready, rsp_payload_outputs_0);
      miscompares++;
    end
    $display("mid-job reset applied at cycle %0d", cyc);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    send_cmd(7'd0, 1'b0, 32'd0, 32'h100, 32'd0, 1);
    get_rsp("cfg_base_after_reset");
    send_cmd(7'd2, 1'b0, 32'd0, 32'd4, 32'd4128, 7);
    get_rsp("start_after_reset");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 32'h0101_0101;
      mem_b[32'h100 + i] = 32'h0202_0202;
    end
    mem_a[12'hFFE] = 32'h0303_0303;
    mem_a[12'hFFF] = 32'h0303_0303;
    mem_b[12'h0FE] = 32'hFF01_FF01;
    mem_b[12'h0FF] = 32'hFF01_FF01;
    @(negedge clk);
    test_reset();
    test_basic_job();
    test_chain();
    test_len_zero();
    test_patterns();
    test_hold();
    test_reset_mid_job();
    vectors++;
    if (overlap_cnt !== 0) begin
      $display("FAIL clear_valid_overlap: got %0d cycles required 0", overlap_cnt);
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
